// File: rtl/if_id_pipe_reg_pkg.sv
// rtl/if_id_pipe_reg_pkg.sv - default widths, field offsets and state encoding for the IF/ID register
package cpu_pipe_pkg;

    localparam int DEFAULT_INSTR_W = 32;
    localparam int DEFAULT_PC_W    = 32;
    localparam int DEFAULT_OP_W    = 4;
    localparam int DEFAULT_REG_W   = 6;
    localparam int NOP_OP          = 0;

    localparam int OP_LSB = DEFAULT_INSTR_W - DEFAULT_OP_W;
    localparam int RD_LSB = OP_LSB - DEFAULT_REG_W;
    localparam int RS_LSB = RD_LSB - DEFAULT_REG_W;
    localparam int RT_LSB = RS_LSB - DEFAULT_REG_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } ifid_state_t;

    // idx 0 = opcode, 1 = rd, 2 = rs, 3 = rt; fields packed MSB-first from the top of width
    function automatic int field_lsb(input int width, input int op_w, input int reg_w, input int idx);
        if (idx == 0) return width - op_w;
        return width - op_w - idx * reg_w;
    endfunction

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// rtl/if_id_pipe_reg_if.sv - fetch-side and decode-side handshake bundle of the IF/ID register
interface if_id_pipe_reg_if
    import cpu_pipe_pkg::*;
#(
    parameter int INSTR_W = DEFAULT_INSTR_W,
    parameter int PC_W    = DEFAULT_PC_W,
    parameter int OP_W    = DEFAULT_OP_W,
    parameter int REG_W   = DEFAULT_REG_W
);

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_if;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [OP_W-1:0]    opcode;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [INSTR_W-1:0] instr_id;
    logic [PC_W-1:0]    pc_id;

    modport master (
        output in_valid, instr, pc_if, flush, out_ready,
        input  in_ready, out_valid, opcode, rd, rs, rt, instr_id, pc_id
    );

    modport slave (
        input  in_valid, instr, pc_if, flush, out_ready,
        output in_ready, out_valid, opcode, rd, rs, rt, instr_id, pc_id
    );

endinterface

// File: rtl/if_id_pipe_reg_instr_field_split.sv
// rtl/if_id_pipe_reg_instr_field_split.sv - splits the held instruction into opcode/rd/rs/rt with bubble masking
module instr_field_split
    import cpu_pipe_pkg::*;
#(
    parameter int OP_W   = DEFAULT_OP_W,
    parameter int REG_W  = DEFAULT_REG_W,
    parameter int NOP_OP = cpu_pipe_pkg::NOP_OP
) (
    input  logic [OP_W+3*REG_W-1:0] fields_i,
    input  logic                    valid_i,
    output logic [OP_W-1:0]         opcode_o,
    output logic [REG_W-1:0]        rd_o,
    output logic [REG_W-1:0]        rs_o,
    output logic [REG_W-1:0]        rt_o
);

    localparam int FIELDS_W = OP_W + 3 * REG_W;
    localparam int OP_L     = field_lsb(FIELDS_W, OP_W, REG_W, 0);
    localparam int RD_L     = field_lsb(FIELDS_W, OP_W, REG_W, 1);
    localparam int RS_L     = field_lsb(FIELDS_W, OP_W, REG_W, 2);
    localparam int RT_L     = field_lsb(FIELDS_W, OP_W, REG_W, 3);

    always_comb begin
        opcode_o = OP_W'(NOP_OP);
        rd_o     = '0;
        rs_o     = '0;
        rt_o     = '0;
        if (valid_i) begin
            opcode_o = fields_i[OP_L +: OP_W];
            rd_o     = fields_i[RD_L +: REG_W];
            rs_o     = fields_i[RS_L +: REG_W];
            rt_o     = fields_i[RT_L +: REG_W];
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - IF/ID pipeline register with 2-entry skid buffer; IFID_PERF_CNT_EN adds stall/flush counters
module if_id_pipe_reg
    import cpu_pipe_pkg::*;
#(
    parameter int INSTR_W = DEFAULT_INSTR_W,
    parameter int PC_W    = DEFAULT_PC_W,
    parameter int OP_W    = DEFAULT_OP_W,
    parameter int REG_W   = DEFAULT_REG_W,
    parameter int NOP_OP  = cpu_pipe_pkg::NOP_OP
) (
    input  logic           clock,
    input  logic           reset,
    if_id_pipe_reg_if.slave bus
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]    stall_cnt,
    output logic [15:0]    flush_cnt
`endif
);

    localparam int FIELDS_W = OP_W + 3 * REG_W;

    if (FIELDS_W > INSTR_W) begin : g_width_check
        $fatal(1, "if_id_pipe_reg: OP_W + 3*REG_W exceeds INSTR_W");
    end

    ifid_state_t        state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

    logic in_fire;
    logic out_fire;
    logic out_valid;

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = bus.in_valid & in_ready_q;
    assign out_fire  = out_valid & bus.out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (bus.flush) begin
            // redirect wins over everything; the flush-cycle offer is dropped
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = ONE;
                        main_instr_d = bus.instr;
                        main_pc_d    = bus.pc_if;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_instr_d = bus.instr;
                        main_pc_d    = bus.pc_if;
                    end else if (in_fire) begin
                        state_d      = TWO;
                        skid_instr_d = bus.instr;
                        skid_pc_d    = bus.pc_if;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d      = ONE;
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.instr_id  = main_instr_q;
    assign bus.pc_id     = main_pc_q;

    instr_field_split #(
        .OP_W   (OP_W),
        .REG_W  (REG_W),
        .NOP_OP (NOP_OP)
    ) u_split (
        .fields_i (main_instr_q[INSTR_W-1 -: FIELDS_W]),
        .valid_i  (out_valid),
        .opcode_o (bus.opcode),
        .rd_o     (bus.rd),
        .rs_o     (bus.rs),
        .rt_o     (bus.rt)
    );

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !bus.out_ready && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.flush && (state_q != EMPTY) && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb/tb_if_id_pipe_reg.sv - self-checking bench for if_id_pipe_reg at default and widened parameters
module tb_if_id_pipe_reg;

    logic clock;
    logic reset;

    if_id_pipe_reg_if bus_a ();
    if_id_pipe_reg_if #(.INSTR_W(40), .PC_W(16), .OP_W(6), .REG_W(8)) bus_b ();

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt_a, stall_cnt_b;
    logic [15:0] flush_cnt_a, flush_cnt_b;
`endif

    if_id_pipe_reg dut_a (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus_a)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt_a),
        .flush_cnt (flush_cnt_a)
`endif
    );

    if_id_pipe_reg #(.INSTR_W(40), .PC_W(16), .OP_W(6), .REG_W(8)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus_b)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt_b),
        .flush_cnt (flush_cnt_b)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ia;
        logic [31:0] pa;
        logic [39:0] ib;
        logic [15:0] pb;
    } ent_t;

    ent_t q[$];
    bit   rdy_m;
    int   stall_m;
    int   flush_m;
    int   n_assert;
    int   n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rdy_m   = 1'b1;
        stall_m = 0;
        flush_m = 0;
    endtask

    // Reference: a FIFO of at most two accepted entries; the head is what decode sees
    task automatic model_edge();
        bit   in_f, out_f;
        ent_t e;
        in_f  = bus_a.in_valid && rdy_m;
        out_f = (q.size() > 0) && bus_a.out_ready;
        if ((q.size() > 0) && !bus_a.out_ready) stall_m++;
        if (bus_a.flush && (q.size() > 0)) flush_m++;
        if (bus_a.flush) begin
            q.delete();
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f) begin
                e.ia = bus_a.instr;
                e.pa = bus_a.pc_if;
                e.ib = bus_b.instr;
                e.pb = bus_b.pc_if;
                q.push_back(e);
            end
        end
        rdy_m = (q.size() < 2);
    endtask

    task automatic check_all();
        bit   v;
        ent_t h;
        v = (q.size() > 0);
        chk("a_in_ready", 64'(bus_a.in_ready), 64'(rdy_m));
        chk("b_in_ready", 64'(bus_b.in_ready), 64'(rdy_m));
        chk("a_out_valid", 64'(bus_a.out_valid), 64'(v));
        chk("b_out_valid", 64'(bus_b.out_valid), 64'(v));
        if (v) begin
            h = q[0];
            chk("a_opcode", 64'(bus_a.opcode), 64'(h.ia >> 28));
            chk("a_rd", 64'(bus_a.rd), 64'((h.ia >> 22) & 32'h3F));
            chk("a_rs", 64'(bus_a.rs), 64'((h.ia >> 16) & 32'h3F));
            chk("a_rt", 64'(bus_a.rt), 64'((h.ia >> 10) & 32'h3F));
            chk("a_instr_id", 64'(bus_a.instr_id), 64'(h.ia));
            chk("a_pc_id", 64'(bus_a.pc_id), 64'(h.pa));
            chk("b_opcode", 64'(bus_b.opcode), 64'(h.ib >> 34));
            chk("b_rd", 64'(bus_b.rd), 64'((h.ib >> 26) & 40'hFF));
            chk("b_rs", 64'(bus_b.rs), 64'((h.ib >> 18) & 40'hFF));
            chk("b_rt", 64'(bus_b.rt), 64'((h.ib >> 10) & 40'hFF));
            chk("b_instr_id", 64'(bus_b.instr_id), 64'(h.ib));
            chk("b_pc_id", 64'(bus_b.pc_id), 64'(h.pb));
        end else begin
            chk("a_bubble_op", 64'(bus_a.opcode), 64'd0);
            chk("a_bubble_regs", 64'({bus_a.rd, bus_a.rs, bus_a.rt}), 64'd0);
            chk("b_bubble_op", 64'(bus_b.opcode), 64'd0);
            chk("b_bubble_regs", 64'({bus_b.rd, bus_b.rs, bus_b.rt}), 64'd0);
        end
`ifdef IFID_PERF_CNT_EN
        chk("a_stall_cnt", 64'(stall_cnt_a), 64'(stall_m));
        chk("a_flush_cnt", 64'(flush_cnt_a), 64'(flush_m));
        chk("b_stall_cnt", 64'(stall_cnt_b), 64'(stall_m));
        chk("b_flush_cnt", 64'(flush_cnt_b), 64'(flush_m));
`endif
    endtask

    task automatic drive(input bit v, input bit r, input bit f);
        bus_a.in_valid  = v;
        bus_b.in_valid  = v;
        bus_a.out_ready = r;
        bus_b.out_ready = r;
        bus_a.flush     = f;
        bus_b.flush     = f;
        bus_a.instr     = $urandom;
        bus_a.pc_if     = $urandom;
        bus_b.instr     = {8'($urandom), 32'($urandom)};
        bus_b.pc_if     = 16'($urandom);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_a_instr_id", 64'(bus_a.instr_id), 64'd0);
        chk("rst_a_pc_id", 64'(bus_a.pc_id), 64'd0);
        chk("rst_b_instr_id", 64'(bus_b.instr_id), 64'd0);
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    logic [31:0] first_ia;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_all();
        chk("reset_in_ready", 64'(bus_a.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("reset_opcode", 64'(bus_a.opcode), 64'd0);
        chk("reset_pc_id", 64'(bus_a.pc_id), 64'd0);
        step();

        // back-to-back streaming of four instructions
        drive(1'b1, 1'b1, 1'b0);
        bus_a.instr = 32'h50A3_0C00;
        bus_a.pc_if = 32'h100;
        bus_b.instr = 40'hAB_CDEF_1234;
        bus_b.pc_if = 16'h0100;
        step();
        chk("stream_opcode", 64'(bus_a.opcode), 64'h5);
        chk("stream_rd", 64'(bus_a.rd), 64'h02);
        chk("stream_rs", 64'(bus_a.rs), 64'h23);
        chk("stream_rt", 64'(bus_a.rt), 64'h03);
        chk("stream_pc_id", 64'(bus_a.pc_id), 64'h100);
        chk("wide_opcode", 64'(bus_b.opcode), 64'h2A);
        chk("wide_rd", 64'(bus_b.rd), 64'hF3);
        chk("wide_rs", 64'(bus_b.rs), 64'h7B);
        chk("wide_rt", 64'(bus_b.rt), 64'hC4);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 1'b0);
        step();
        step();

        // stall: two accepted, third refused, then release
        drive(1'b1, 1'b0, 1'b0);
        first_ia = bus_a.instr;
        step();
        drive(1'b1, 1'b0, 1'b0);
        step();
        chk("stall_in_ready", 64'(bus_a.in_ready), 64'd0);
        chk("stall_hold_first", 64'(bus_a.instr_id), 64'(first_ia));
        drive(1'b1, 1'b0, 1'b0);
        step();
        chk("stall_frozen", 64'(bus_a.instr_id), 64'(first_ia));
        drive(1'b0, 1'b1, 1'b0);
        step();
        step();
        chk("drained_valid", 64'(bus_a.out_valid), 64'd0);

        // flush while full with a new offer present
        drive(1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1);
        step();
        chk("flush_valid", 64'(bus_a.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus_a.in_ready), 64'd1);
        chk("flush_nop", 64'(bus_a.opcode), 64'd0);
        drive(1'b0, 1'b1, 1'b0);
        step();
        chk("flush_dropped", 64'(bus_a.out_valid), 64'd0);

        // asynchronous reset while full and stalled
        drive(1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0);
        step();
        chk("pre_reset_full", 64'(bus_a.in_ready), 64'd0);
        async_reset();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
            step();
        end

        // counter scenario: five stall cycles, two flushes of a non-empty buffer
        drive(1'b0, 1'b1, 1'b0);
        async_reset();
        drive(1'b1, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 1'b1);
        step();
        drive(1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b1);
        step();
        drive(1'b0, 1'b1, 1'b0);
        step();
`ifdef IFID_PERF_CNT_EN
        chk("perf_stall_5", 64'(stall_cnt_a), 64'd5);
        chk("perf_flush_2", 64'(flush_cnt_a), 64'd2);
`endif
        chk("end_idle", 64'(bus_a.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Parametrised IF/ID pipeline register for the 4-stage CPU. Carries the fetched instruction and PC from fetch to decode with a valid/ready handshake, stall back-pressure and flush-to-bubble. A 2-entry skid buffer keeps in_ready registered. Instruction fields are split at the output.

Parameters:
INSTR_W, 32, instruction width in bits
PC_W, 32, program counter width
OP_W, 4, opcode field width, taken from the MSBs of the instruction
REG_W, 6, width of each register specifier; rd, rs and rt follow the opcode, MSB-first
NOP_OP, 0, opcode presented on the output when out_valid=0

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  fetch presents instr/pc_if
in_ready  out  1  buffer can accept; registered
instr  in  INSTR_W  fetched instruction
pc_if  in  PC_W  PC of the fetched instruction
flush  in  1  branch/jump redirect; discards all held entries
out_valid  out  1  decode-stage entry valid
out_ready  in  1  decode accepts; 0 = stall
opcode  out  OP_W  instr[INSTR_W-1 -: OP_W]
rd  out  REG_W  next REG_W bits below opcode
rs  out  REG_W  next REG_W bits below rd
rt  out  REG_W  next REG_W bits below rs
instr_id  out  INSTR_W  raw held instruction
pc_id  out  PC_W  held PC

Behaviour:
- Elaboration check: OP_W + 3*REG_W <= INSTR_W, otherwise a fatal error.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry. States: EMPTY, ONE, TWO (FSM register, 2 bits).
- EMPTY:
  - in_fire -> ONE; main <= input.
- ONE:
  - in_fire & out_fire -> ONE; main <= input.
  - in_fire & !out_fire -> TWO; skid <= input.
  - !in_fire & out_fire -> EMPTY.
  - else hold.
- TWO:
  - out_fire -> ONE; main <= skid.
  - else hold.
  - in_fire is impossible because in_ready=0.
- in_ready is a register, set to (next_state != TWO). Its reset value is 1.
- out_valid = (state != EMPTY).
- Latency: 1 cycle from in_fire in EMPTY to out_valid.
- Throughput: 1 instruction/cycle while out_ready=1.
- Stall (out_ready=0): main entry and all outputs hold stable. At most one further instruction is absorbed, into skid.
- Flush:
  - Highest priority. Next state is EMPTY and in_ready becomes 1, whatever the handshake did.
  - An instruction offered in the flush cycle is dropped even if in_valid & in_ready.
  - An out_fire in the flush cycle still counts as consumed by decode.
- Bubble outputs: when out_valid=0, opcode=NOP_OP and rd=rs=rt=0. instr_id and pc_id hold their last value; they are don't-care.
- Reset (async, any time, including mid-stall in TWO):
  - state=EMPTY, in_ready=1, out_valid=0.
  - main and skid payloads cleared to 0, so opcode=NOP_OP and rd/rs/rt/instr_id/pc_id=0.
- Flush and reset with simultaneous stall: the result is EMPTY in both cases; the stall is irrelevant.
- The PC is carried unmodified; no arithmetic, so no wrap-around concerns.

Optional Feature:
IFID_PERF_CNT_EN
- Defined:
  - Adds outputs stall_cnt (32) and flush_cnt (16).
  - stall_cnt increments on each cycle with out_valid & !out_ready.
  - flush_cnt increments on each cycle with flush=1 while state != EMPTY.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent; everything else is unchanged.

Decomposition:
- Package cpu_pipe_pkg holds:
  - OP_W, REG_W, INSTR_W defaults;
  - field offset localparams (OP_LSB, RD_LSB, RS_LSB, RT_LSB);
  - ifid_state_t enum {EMPTY, ONE, TWO};
  - NOP_OP.
- One sub-module: instr_field_split, purely combinational. It splits the held instruction into opcode/rd/rs/rt and applies bubble masking from out_valid.
- Storage and FSM stay in if_id_pipe_reg.

Test Plan:
- Reset held, then released, with in_valid=0 -> in_ready=1, out_valid=0, opcode=0, pc_id=0. Assert reset again in state TWO -> immediate EMPTY with outputs cleared.
- Stream 4 instructions back-to-back with out_ready=1, first instr=0x5_0A3_0C00 and pc=0x100 -> out_valid next cycle, opcode=0x5, rd=0x02, rs=0x23, rt=0x03, pc_id=0x100. Then one output per cycle, in order.
- Two instructions offered with out_ready=0 -> state TWO, in_ready=0, outputs frozen on the first. Release out_ready -> second appears the next cycle with no loss or duplication.
- Assert flush in state TWO while in_valid=1 -> next cycle out_valid=0, opcode=NOP_OP, in_ready=1. The flush-cycle instruction never appears.
- Build with non-default widths (INSTR_W=40, PC_W=16, OP_W=6, REG_W=8) and run the streaming test -> fields extracted at the recomputed offsets.
- Build with IFID_PERF_CNT_EN, run 5 stall cycles and 2 flushes of non-empty state -> stall_cnt=5, flush_cnt=2. Confirm the build without the macro compiles without these ports.
